// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one ALU between two requesters. It grants
// requests round-robin, runs the ALU op and returns a held response.
// Optional build macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins ties.
// Ports:
//   CLK, RST (async, active-low)
//   req0/req1 : valid/ready + op1/op2/oprn payload (ready is combinational)
//   rsp0/rsp1 : valid/ready; shared rsp_rh/rsp_rl/rsp_zero/rsp_err
//   alu_*     : operand/opcode out, rh/rl/done/zero in
module alu_req_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int OPRN_WIDTH = 6,
   parameter int TIMEOUT    = 64
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [DATA_WIDTH-1:0] req0_op1,
   input  logic [DATA_WIDTH-1:0] req0_op2,
   input  logic [OPRN_WIDTH-1:0] req0_oprn,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [DATA_WIDTH-1:0] req1_op1,
   input  logic [DATA_WIDTH-1:0] req1_op2,
   input  logic [OPRN_WIDTH-1:0] req1_oprn,
   output logic                  rsp0_valid,
   input  logic                  rsp0_ready,
   output logic                  rsp1_valid,
   input  logic                  rsp1_ready,
   output logic [DATA_WIDTH-1:0] rsp_rh,
   output logic [DATA_WIDTH-1:0] rsp_rl,
   output logic                  rsp_zero,
   output logic                  rsp_err,
   output logic [DATA_WIDTH-1:0] alu_op1,
   output logic [DATA_WIDTH-1:0] alu_op2,
   output logic [OPRN_WIDTH-1:0] alu_oprn,
   input  logic [DATA_WIDTH-1:0] alu_rh,
   input  logic [DATA_WIDTH-1:0] alu_rl,
   input  logic                  alu_done,
   input  logic                  alu_zero
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t                state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic                  grant_q, grant_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] op1_q, op1_d;
   logic [DATA_WIDTH-1:0] op2_q, op2_d;
   logic [OPRN_WIDTH-1:0] oprn_q, oprn_d;
   logic [DATA_WIDTH-1:0] rh_q, rh_d;
   logic [DATA_WIDTH-1:0] rl_q, rl_d;
   logic                  zero_q, zero_d;
   logic                  err_q, err_d;
   logic                  v0_q, v0_d;
   logic                  v1_q, v1_d;

   logic idle;
   logic win1;
   logic rsp_ack;

   assign idle = (state_q == S_IDLE);

   // win1: requester 1 is the winner if it requests and requester 0
   // either does not, or (round-robin) had the last grant.
`ifdef ALU_ARB_FIXED_PRIO_EN
   assign win1 = req1_valid & ~req0_valid;
`else
   assign win1 = req1_valid & (~req0_valid | ~last_grant_q);
`endif

   // Gated by RST so no grant is offered while reset is held.
   assign req0_ready = RST & idle & req0_valid & ~win1;
   assign req1_ready = RST & idle & win1;

   // Only the granted port's ready can close the response.
   assign rsp_ack = grant_q ? rsp1_ready : rsp0_ready;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      cnt_d        = cnt_q;
      op1_d        = op1_q;
      op2_d        = op2_q;
      oprn_d       = oprn_q;
      rh_d         = rh_q;
      rl_d         = rl_q;
      zero_d       = zero_q;
      err_d        = err_q;
      v0_d         = v0_q;
      v1_d         = v1_q;
      unique case (state_q)
         S_IDLE: begin
            if (req0_ready | req1_ready) begin
               grant_d      = win1;
               last_grant_d = win1;
               cnt_d        = '0;
               op1_d        = win1 ? req1_op1 : req0_op1;
               op2_d        = win1 ? req1_op2 : req0_op2;
               oprn_d       = win1 ? req1_oprn : req0_oprn;
               state_d      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // done may still be high from the previous op here
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + 8'd1;
            if (alu_done) begin
               rh_d    = alu_rh;
               rl_d    = alu_rl;
               zero_d  = alu_zero;
               err_d   = 1'b0;
               v0_d    = ~grant_q;
               v1_d    = grant_q;
               state_d = S_RESP;
            end else if (cnt_q == TMO_LAST) begin
               rh_d    = '0;
               rl_d    = '0;
               zero_d  = 1'b0;
               err_d   = 1'b1;
               v0_d    = ~grant_q;
               v1_d    = grant_q;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ack) begin
               v0_d    = 1'b0;
               v1_d    = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         cnt_q        <= '0;
         op1_q        <= '0;
         op2_q        <= '0;
         oprn_q       <= '0;
         rh_q         <= '0;
         rl_q         <= '0;
         zero_q       <= 1'b0;
         err_q        <= 1'b0;
         v0_q         <= 1'b0;
         v1_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         cnt_q        <= cnt_d;
         op1_q        <= op1_d;
         op2_q        <= op2_d;
         oprn_q       <= oprn_d;
         rh_q         <= rh_d;
         rl_q         <= rl_d;
         zero_q       <= zero_d;
         err_q        <= err_d;
         v0_q         <= v0_d;
         v1_q         <= v1_d;
      end
   end

   assign alu_op1    = op1_q;
   assign alu_op2    = op2_q;
   assign alu_oprn   = oprn_q;
   assign rsp_rh     = rh_q;
   assign rsp_rl     = rl_q;
   assign rsp_zero   = zero_q;
   assign rsp_err    = err_q;
   assign rsp0_valid = v0_q;
   assign rsp1_valid = v1_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed table, hand sequences and random
// transactions checked against a transaction-level arbiter/ALU model.
module tb_alu_req_arbiter;

   localparam int TMO = 64;
`ifdef ALU_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic        CLK, RST;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
   logic [5:0]  req0_oprn, req1_oprn;
   logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [31:0] rsp_rh, rsp_rl;
   logic        rsp_zero, rsp_err;
   logic [31:0] alu_op1, alu_op2;
   logic [5:0]  alu_oprn;
   logic [31:0] alu_rh, alu_rl;
   logic        alu_done, alu_zero;

   alu_req_arbiter #(
      .DATA_WIDTH(32),
      .OPRN_WIDTH(6),
      .TIMEOUT   (TMO)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .req0_valid(req0_valid),
      .req0_ready(req0_ready),
      .req0_op1  (req0_op1),
      .req0_op2  (req0_op2),
      .req0_oprn (req0_oprn),
      .req1_valid(req1_valid),
      .req1_ready(req1_ready),
      .req1_op1  (req1_op1),
      .req1_op2  (req1_op2),
      .req1_oprn (req1_oprn),
      .rsp0_valid(rsp0_valid),
      .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid),
      .rsp1_ready(rsp1_ready),
      .rsp_rh    (rsp_rh),
      .rsp_rl    (rsp_rl),
      .rsp_zero  (rsp_zero),
      .rsp_err   (rsp_err),
      .alu_op1   (alu_op1),
      .alu_op2   (alu_op2),
      .alu_oprn  (alu_oprn),
      .alu_rh    (alu_rh),
      .alu_rl    (alu_rl),
      .alu_done  (alu_done),
      .alu_zero  (alu_zero)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;
   int lg       = 1;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference ALU: {rh, rl}
   function automatic logic [63:0] alu_fn(input logic [5:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
      case (op)
         6'h01:   return {32'd0, a + b};
         6'h02:   return {32'd0, a - b};
         6'h03:   return 64'(a) * 64'(b);
         6'h06:   return {32'd0, a & b};
         default: return 64'd0;
      endcase
   endfunction

   // Arbitration rule: sole requester wins; on a tie the port that
   // did not win last time (or port 0 under fixed priority).
   function automatic int model_win(input logic v0, input logic v1);
      if (v0 && v1) return FIXED ? 0 : (1 - lg);
      return v1 ? 1 : 0;
   endfunction

   // One full transaction from accept cycle to response handshake.
   // dlat = cycles after ISSUE until done (0: never, timeout).
   task automatic txn(input string tag, input logic v0, input logic v1,
                      input logic [31:0] a0, input logic [31:0] b0,
                      input logic [5:0] o0,
                      input logic [31:0] a1, input logic [31:0] b1,
                      input logic [5:0] o1,
                      input int dlat, input int bp, input logic stale,
                      input int ew, input logic [31:0] erh,
                      input logic [31:0] erl, input logic ez,
                      input logic ee);
      int          ecyc;
      logic [31:0] ea, eb;
      logic [5:0]  eo;
      logic [63:0] r;
      logic        early;
      logic        stable;
      logic [69:0] snap;
      ecyc  = (dlat > 0) ? dlat + 2 : TMO + 2;
      ea    = (ew != 0) ? a1 : a0;
      eb    = (ew != 0) ? b1 : b0;
      eo    = (ew != 0) ? o1 : o0;
      early = 1'b0;
      // cycle 0: accept
      req0_valid = v0;
      req1_valid = v1;
      req0_op1   = a0;
      req0_op2   = b0;
      req0_oprn  = o0;
      req1_op1   = a1;
      req1_op2   = b1;
      req1_oprn  = o1;
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      alu_done   = 1'b0;
      alu_rh     = 32'hDEADBEEF;
      alu_rl     = 32'hDEADBEEF;
      alu_zero   = 1'b1;
      #1;
      chk({tag, ".grant"}, 64'({req1_ready, req0_ready}),
          64'((ew != 0) ? 2'b10 : 2'b01));
      // cycle 1: issue, stale done presented
      @(negedge CLK);
      if (ew != 0) req1_valid = 1'b0;
      else req0_valid = 1'b0;
      alu_done = stale;
      #1;
      chk({tag, ".issue_rdy"}, 64'({req1_ready, req0_ready}), 64'd0);
      chk({tag, ".alu_ops"}, {alu_op1, alu_op2}, {ea, eb});
      chk({tag, ".alu_oprn"}, 64'(alu_oprn), 64'(eo));
      for (int c = 2; c < ecyc; c++) begin
         @(negedge CLK);
         if (dlat > 0 && c == dlat + 1) begin
            r        = alu_fn(alu_oprn, alu_op1, alu_op2);
            alu_rh   = r[63:32];
            alu_rl   = r[31:0];
            alu_zero = (r[31:0] == 32'd0);
            alu_done = 1'b1;
         end else begin
            alu_done = 1'b0;
            alu_rh   = 32'hDEADBEEF;
            alu_rl   = 32'hDEADBEEF;
            alu_zero = 1'b1;
         end
         #1;
         if (rsp0_valid | rsp1_valid | req0_ready | req1_ready)
            early = 1'b1;
      end
      chk({tag, ".quiet"}, 64'(early), 64'd0);
      // response cycle
      @(negedge CLK);
      alu_done = 1'b0;
      alu_rh   = 32'hDEADBEEF;
      alu_rl   = 32'hDEADBEEF;
      #1;
      chk({tag, ".rsp_v"}, 64'({rsp1_valid, rsp0_valid}),
          64'((ew != 0) ? 2'b10 : 2'b01));
      chk({tag, ".rsp_res"}, {rsp_rh, rsp_rl}, {erh, erl});
      chk({tag, ".rsp_ze"}, 64'({rsp_zero, rsp_err}), 64'({ez, ee}));
      chk({tag, ".alu_hold"}, {alu_op1, alu_op2}, {ea, eb});
      snap   = {rsp1_valid, rsp0_valid, rsp_rh, rsp_rl, rsp_zero, rsp_err,
                req1_ready, req0_ready};
      stable = 1'b1;
      // backpressure; the other port's ready must be ignored
      for (int k = 0; k < bp; k++) begin
         if (ew != 0) rsp0_ready = 1'b1;
         else rsp1_ready = 1'b1;
         @(negedge CLK);
         #1;
         if ({rsp1_valid, rsp0_valid, rsp_rh, rsp_rl, rsp_zero, rsp_err,
              req1_ready, req0_ready} !== snap)
            stable = 1'b0;
      end
      if (bp > 0) chk({tag, ".bp_stable"}, 64'(stable), 64'd1);
      rsp0_ready = (ew == 0);
      rsp1_ready = (ew != 0);
      @(negedge CLK);
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      #1;
      chk({tag, ".rsp_drop"}, 64'({rsp1_valid, rsp0_valid}), 64'd0);
      lg = ew;
   endtask

   typedef struct {
      logic        v0, v1;
      logic [31:0] a0, b0;
      logic [5:0]  o0;
      logic [31:0] a1, b1;
      logic [5:0]  o1;
      int          dlat, bp;
      logic        stale;
      int          ew;
      logic [31:0] erh, erl;
      logic        ez, ee;
   } vec_t;

   vec_t tbl[12];

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0]  ops[4];
      logic [31:0] rnd;
      logic        rv0, rv1, rst;
      int          rw, rdl, rbp;
      logic [31:0] ra0, rb0, ra1, rb1;
      logic [5:0]  ro0, ro1;
      logic [63:0] rr;
      logic        seen;
      ops = '{6'h01, 6'h02, 6'h03, 6'h06};

      tbl[0]  = '{1'b1, 1'b0, 32'd15, 32'd3, 6'h01, 32'd0, 32'd0, 6'h00,
                  1, 0, 1'b0, 0, 32'd0, 32'd18, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 32'd15, 32'd5, 6'h02, 32'd15, 32'd5, 6'h06,
                  1, 0, 1'b0, FIXED ? 0 : 1, 32'd0,
                  FIXED ? 32'd10 : 32'd5, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 32'd15, 32'd5, 6'h02, 32'd15, 32'd5, 6'h06,
                  1, 0, 1'b0, 0, 32'd0, 32'd10, 1'b0, 1'b0};
      tbl[3]  = tbl[1];
      tbl[4]  = tbl[2];
      tbl[5]  = '{1'b1, 1'b1, 32'd7, 32'd8, 6'h01, 32'h10000, 32'h30000,
                  6'h03, 2, 10, 1'b1, FIXED ? 0 : 1,
                  FIXED ? 32'd0 : 32'd3, FIXED ? 32'd15 : 32'd0,
                  FIXED ? 1'b0 : 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 32'd3, 32'd5, 6'h02, 32'd0, 32'd0, 6'h00,
                  3, 0, 1'b1, 0, 32'd0, 32'hFFFFFFFE, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 32'd0, 32'd0, 6'h00, 32'hF0, 32'h0F, 6'h06,
                  2, 1, 1'b1, 1, 32'd0, 32'd0, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 32'd1, 32'd1, 6'h01, 32'd0, 32'd0, 6'h00,
                  0, 0, 1'b0, 0, 32'd0, 32'd0, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 1'b1, 32'd0, 32'd0, 6'h00, 32'd100, 32'd200, 6'h01,
                  TMO, 0, 1'b0, 1, 32'd0, 32'd300, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'd1, 6'h01, 32'd0, 32'd0,
                  6'h00, 1, 0, 1'b1, 0, 32'd0, 32'd0, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 32'd0, 32'd0, 6'h00, 32'd6, 32'd7, 6'h03,
                  4, 2, 1'b0, 1, 32'd0, 32'd42, 1'b0, 1'b0};

      RST        = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_op1   = '0;
      req0_op2   = '0;
      req0_oprn  = '0;
      req1_op1   = '0;
      req1_op2   = '0;
      req1_oprn  = '0;
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      alu_rh     = '0;
      alu_rl     = '0;
      alu_done   = 1'b0;
      alu_zero   = 1'b0;
      #1;
      chk("reset.ctrl", 64'({req0_ready, req1_ready, rsp0_valid,
                            rsp1_valid, rsp_zero, rsp_err}), 64'd0);
      chk("reset.rsp", {rsp_rh, rsp_rl}, 64'd0);
      chk("reset.alu", {alu_op1, alu_op2}, 64'd0);
      chk("reset.oprn", 64'(alu_oprn), 64'd0);
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);

      for (int i = 0; i < 12; i++)
         txn($sformatf("tbl%0d", i), tbl[i].v0, tbl[i].v1, tbl[i].a0,
             tbl[i].b0, tbl[i].o0, tbl[i].a1, tbl[i].b1, tbl[i].o1,
             tbl[i].dlat, tbl[i].bp, tbl[i].stale, tbl[i].ew, tbl[i].erh,
             tbl[i].erl, tbl[i].ez, tbl[i].ee);

      // reset while waiting on the ALU
      req0_valid = 1'b1;
      req1_valid = 1'b0;
      req0_op1   = 32'd55;
      req0_op2   = 32'd66;
      req0_oprn  = 6'h01;
      @(negedge CLK);
      req0_valid = 1'b0;
      @(negedge CLK);
      #1;
      chk("rstwait.pre", 64'(alu_op1), 64'd55);
      #1;
      RST = 1'b0;
      #1;
      chk("rstwait.ctrl", 64'({req0_ready, req1_ready, rsp0_valid,
                              rsp1_valid, rsp_zero, rsp_err}), 64'd0);
      chk("rstwait.rsp", {rsp_rh, rsp_rl}, 64'd0);
      chk("rstwait.alu", {alu_op1, alu_op2}, 64'd0);
      chk("rstwait.oprn", 64'(alu_oprn), 64'd0);
      @(negedge CLK);
      RST  = 1'b1;
      lg   = 1;
      seen = 1'b0;
      alu_done = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge CLK);
         #1;
         if (rsp0_valid | rsp1_valid) seen = 1'b1;
      end
      alu_done = 1'b0;
      chk("rstwait.no_rsp", 64'(seen), 64'd0);

      // contention straight after reset, then the pending port 1
      txn("cont0", 1'b1, 1'b1, 32'd1, 32'd2, 6'h01, 32'd9, 32'd4, 6'h02,
          1, 0, 1'b0, 0, 32'd0, 32'd3, 1'b0, 1'b0);
      txn("cont1", 1'b0, 1'b1, 32'd1, 32'd2, 6'h01, 32'd9, 32'd4, 6'h02,
          1, 0, 1'b0, 1, 32'd0, 32'd5, 1'b0, 1'b0);

      // randomized transactions against the model
      for (int n = 0; n < 40; n++) begin
         rnd = $urandom;
         rv0 = rnd[0];
         rv1 = rnd[1];
         if (!rv0 && !rv1) rv0 = 1'b1;
         ra0 = $urandom;
         rb0 = $urandom;
         ra1 = $urandom;
         rb1 = $urandom;
         ro0 = ops[rnd[3:2]];
         ro1 = ops[rnd[5:4]];
         rdl = 1 + int'(rnd[8:6]) % 6;
         rbp = int'(rnd[10:9]);
         rst = rnd[11];
         rw  = model_win(rv0, rv1);
         rr  = (rw != 0) ? alu_fn(ro1, ra1, rb1) : alu_fn(ro0, ra0, rb0);
         txn($sformatf("rnd%0d", n), rv0, rv1, ra0, rb0, ro0, ra1, rb1, ro1,
             rdl, rbp, rst, rw, rr[63:32], rr[31:0], rr[31:0] == 32'd0,
             1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
